// File: rtl/data_mem_ctrl.sv
// Byte-serial memory controller: commits ROB stores and serves LSB loads over
// an 8-bit RAM/IO bus, returning extended load results to the ROB/LSB broadcast.
module data_mem_ctrl #(
   parameter int          ROB_SIZE_WIDTH = 5,
   parameter logic [31:0] IO_ADDR_BASE   = 32'h30000
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      rdy_in,
   input  logic                      io_buffer_full_in,
   input  logic                      rob_flush_in,
   input  logic                      rob_store_valid,
   input  logic [1:0]                rob_store_type,
   input  logic [31:0]               rob_store_addr,
   input  logic [31:0]               rob_store_value,
   input  logic                      lsb_load_valid,
   input  logic [2:0]                lsb_load_type,
   input  logic [31:0]               lsb_load_addr,
   input  logic [ROB_SIZE_WIDTH:0]   lsb_load_dependency,
   output logic                      lsb_load_accept,
   output logic                      mem_busy,
   output logic                      mem_valid,
   output logic [ROB_SIZE_WIDTH:0]   mem_dependency,
   output logic [31:0]               mem_value,
   input  logic [7:0]                mem_din,
   output logic [7:0]                mem_dout,
   output logic [31:0]               mem_a,
   output logic                      mem_wr
);

   typedef enum logic [1:0] {IDLE, STORE, LOAD} state_t;

   state_t                  state_q, state_d;
   logic [2:0]              cnt_q, cnt_d;
   logic [2:0]              size_q, size_d;
   logic [31:0]             addr_q, addr_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [23:0]             rdata_q, rdata_d;
   logic                    ld_signed_q, ld_signed_d;
   logic [ROB_SIZE_WIDTH:0] tag_q, tag_d;
   logic [31:0]             mem_a_q, mem_a_d;
   logic [7:0]              mem_dout_q, mem_dout_d;
   logic                    mem_wr_q, mem_wr_d;
   logic                    accept_q, accept_d;
   logic                    valid_q, valid_d;
   logic [ROB_SIZE_WIDTH:0] dep_q, dep_d;
   logic [31:0]             value_q, value_d;
   logic [31:0]             byte_addr;
   logic [31:0]             ld_result;
   logic                    ext_bit;

   function automatic logic [2:0] acc_size(input logic [1:0] t);
      case (t)
         2'b00:   acc_size = 3'd1;
         2'b01:   acc_size = 3'd2;
         default: acc_size = 3'd4;
      endcase
   endfunction

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      size_d      = size_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      ld_signed_d = ld_signed_q;
      tag_d       = tag_q;
      mem_a_d     = mem_a_q;
      mem_dout_d  = mem_dout_q;
      mem_wr_d    = 1'b0;
      accept_d    = 1'b0;
      valid_d     = 1'b0;
      dep_d       = dep_q;
      value_d     = value_q;
      byte_addr   = addr_q + {29'd0, cnt_q};

      // The final load byte is taken straight from mem_din, not from rdata_q.
      ext_bit = ld_signed_q & mem_din[7];
      case (size_q)
         3'd1:    ld_result = {{24{ext_bit}}, mem_din};
         3'd2:    ld_result = {{16{ext_bit}}, mem_din, rdata_q[7:0]};
         default: ld_result = {mem_din, rdata_q[23:0]};
      endcase

      unique case (state_q)
         IDLE: begin
            if (rob_store_valid) begin
               state_d = STORE;
               addr_d  = rob_store_addr;
               wdata_d = rob_store_value;
               size_d  = acc_size(rob_store_type);
               if (rob_store_addr >= IO_ADDR_BASE && io_buffer_full_in) begin
                  cnt_d = 3'd0;
               end else begin
                  mem_a_d    = rob_store_addr;
                  mem_dout_d = rob_store_value[7:0];
                  mem_wr_d   = 1'b1;
                  cnt_d      = 3'd1;
               end
            end else if (lsb_load_valid && !rob_flush_in) begin
               state_d     = LOAD;
               addr_d      = lsb_load_addr;
               size_d      = acc_size(lsb_load_type[1:0]);
               ld_signed_d = ~lsb_load_type[2];
               tag_d       = lsb_load_dependency;
               accept_d    = 1'b1;
               mem_a_d     = lsb_load_addr;
               cnt_d       = 3'd1;
            end
         end
         STORE: begin
            if (cnt_q == size_q) begin
               state_d = IDLE;
               cnt_d   = 3'd0;
            end else if (!(byte_addr >= IO_ADDR_BASE && io_buffer_full_in)) begin
               mem_a_d  = byte_addr;
               mem_wr_d = 1'b1;
               cnt_d    = cnt_q + 3'd1;
               case (cnt_q[1:0])
                  2'd0:    mem_dout_d = wdata_q[7:0];
                  2'd1:    mem_dout_d = wdata_q[15:8];
                  2'd2:    mem_dout_d = wdata_q[23:16];
                  default: mem_dout_d = wdata_q[31:24];
               endcase
            end
         end
         LOAD: begin
            if (rob_flush_in) begin
               state_d = IDLE;
               cnt_d   = 3'd0;
            end else if (cnt_q == size_q + 3'd1) begin
               state_d = IDLE;
               cnt_d   = 3'd0;
               valid_d = 1'b1;
               dep_d   = tag_q;
               value_d = ld_result;
            end else begin
               if (cnt_q < size_q) mem_a_d = byte_addr;
               case (cnt_q)
                  3'd2:    rdata_d[7:0]   = mem_din;
                  3'd3:    rdata_d[15:8]  = mem_din;
                  3'd4:    rdata_d[23:16] = mem_din;
                  default: ;
               endcase
               cnt_d = cnt_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         size_q      <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         ld_signed_q <= 1'b0;
         tag_q       <= '0;
         mem_a_q     <= '0;
         mem_dout_q  <= '0;
         mem_wr_q    <= 1'b0;
         accept_q    <= 1'b0;
         valid_q     <= 1'b0;
         dep_q       <= '1;
         value_q     <= '0;
      end else if (rdy_in) begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         size_q      <= size_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         ld_signed_q <= ld_signed_d;
         tag_q       <= tag_d;
         mem_a_q     <= mem_a_d;
         mem_dout_q  <= mem_dout_d;
         mem_wr_q    <= mem_wr_d;
         accept_q    <= accept_d;
         valid_q     <= valid_d;
         dep_q       <= dep_d;
         value_q     <= value_d;
      end
   end

   // A flush landing on the result cycle kills the broadcast.
   assign mem_valid       = valid_q & ~rob_flush_in;
   assign mem_busy        = (state_q != IDLE) || rob_store_valid;
   assign lsb_load_accept = accept_q;
   assign mem_dependency  = dep_q;
   assign mem_value       = value_q;
   assign mem_a           = mem_a_q;
   assign mem_dout        = mem_dout_q;
   assign mem_wr          = mem_wr_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a byte RAM model (one-cycle read
// latency) and an IO write recorder for addresses at or above 0x30000.
module tb_data_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst, rdy, io_full, flush;
   logic        st_valid;
   logic [1:0]  st_type;
   logic [31:0] st_addr, st_value;
   logic        ld_valid;
   logic [2:0]  ld_type;
   logic [31:0] ld_addr;
   logic [5:0]  ld_dep;
   logic        ld_accept, busy, mvalid, wr;
   logic [5:0]  mdep;
   logic [31:0] mvalue, maddr;
   logic [7:0]  din = 8'h00;
   logic [7:0]  dout;

   logic [7:0]  ram [0:4095];
   int          io_writes = 0;
   logic [7:0]  io_last = 8'h00;
   int          checks = 0;
   int          failures = 0;

   data_mem_ctrl #(.ROB_SIZE_WIDTH(5), .IO_ADDR_BASE(32'h30000)) dut (
      .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .io_buffer_full_in(io_full),
      .rob_flush_in(flush), .rob_store_valid(st_valid), .rob_store_type(st_type),
      .rob_store_addr(st_addr), .rob_store_value(st_value),
      .lsb_load_valid(ld_valid), .lsb_load_type(ld_type), .lsb_load_addr(ld_addr),
      .lsb_load_dependency(ld_dep), .lsb_load_accept(ld_accept), .mem_busy(busy),
      .mem_valid(mvalid), .mem_dependency(mdep), .mem_value(mvalue),
      .mem_din(din), .mem_dout(dout), .mem_a(maddr), .mem_wr(wr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      din <= ram[maddr[11:0]];
      if (wr) begin
         if (maddr >= 32'h30000) begin
            io_writes <= io_writes + 1;
            io_last   <= dout;
         end else begin
            ram[maddr[11:0]] <= dout;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   // Issue a load, confirm acceptance, then measure cycles to mem_valid.
   task automatic do_load(input string name, input logic [2:0] typ, input logic [31:0] addr,
                          input logic [5:0] tag, input logic [31:0] exp_val, input int exp_lat);
      int lat;
      logic got;
      ld_valid = 1'b1; ld_type = typ; ld_addr = addr; ld_dep = tag;
      tick();
      check({name, "_accept"}, {31'd0, ld_accept}, 32'd1);
      ld_valid = 1'b0;
      lat = 0; got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         tick();
         lat++;
         if (mvalid) got = 1'b1;
      end
      check({name, "_latency"}, lat, exp_lat);
      check({name, "_value"}, mvalue, exp_val);
      check({name, "_dep"}, {26'd0, mdep}, {26'd0, tag});
   endtask

   initial begin
      int   n;
      logic seen;
      for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
      rst = 1'b1; rdy = 1'b1; io_full = 1'b0; flush = 1'b0;
      st_valid = 1'b0; st_type = 2'b00; st_addr = '0; st_value = '0;
      ld_valid = 1'b0; ld_type = 3'b000; ld_addr = '0; ld_dep = '0;
      tick(); tick();
      check("rst_valid", {31'd0, mvalid}, 32'd0);
      check("rst_accept", {31'd0, ld_accept}, 32'd0);
      check("rst_wr", {31'd0, wr}, 32'd0);
      check("rst_addr", maddr, 32'd0);
      check("rst_dout", {24'd0, dout}, 32'd0);
      check("rst_value", mvalue, 32'd0);
      check("rst_dep", {26'd0, mdep}, 32'h3F);
      rst = 1'b0;
      tick();
      check("idle_busy", {31'd0, busy}, 32'd0);

      // SW 0xDEADBEEF @0x100
      st_valid = 1'b1; st_type = 2'b10; st_addr = 32'h100; st_value = 32'hDEADBEEF;
      #1 check("sw_busy_req", {31'd0, busy}, 32'd1);
      tick();
      st_valid = 1'b0;
      check("sw_b0_a", maddr, 32'h100);
      check("sw_b0_d", {24'd0, dout}, 32'hEF);
      check("sw_b0_wr", {31'd0, wr}, 32'd1);
      tick();
      check("sw_b1_a", maddr, 32'h101);
      check("sw_b1_d", {24'd0, dout}, 32'hBE);
      tick();
      check("sw_b2_a", maddr, 32'h102);
      check("sw_b2_d", {24'd0, dout}, 32'hAD);
      tick();
      check("sw_b3_a", maddr, 32'h103);
      check("sw_b3_d", {24'd0, dout}, 32'hDE);
      check("sw_b3_busy", {31'd0, busy}, 32'd1);
      tick();
      check("sw_end_busy", {31'd0, busy}, 32'd0);
      check("sw_end_wr", {31'd0, wr}, 32'd0);
      check("sw_ram", {ram[12'h103], ram[12'h102], ram[12'h101], ram[12'h100]}, 32'hDEADBEEF);

      // Loads of each width and extension
      ram[12'h020] = 8'h80;
      do_load("lb", 3'b000, 32'h20, 6'd7, 32'hFFFFFF80, 2);
      do_load("lbu", 3'b100, 32'h20, 6'd9, 32'h00000080, 2);
      ram[12'h040] = 8'h78; ram[12'h041] = 8'h56; ram[12'h042] = 8'h34; ram[12'h043] = 8'h12;
      do_load("lw", 3'b010, 32'h40, 6'd21, 32'h12345678, 5);
      ram[12'h050] = 8'h01; ram[12'h051] = 8'h80;
      do_load("lh", 3'b001, 32'h50, 6'd3, 32'hFFFF8001, 3);
      do_load("lhu", 3'b101, 32'h50, 6'd4, 32'h00008001, 3);
      ram[12'hFFF] = 8'h34; ram[12'h000] = 8'h12;
      do_load("lhu_wrap", 3'b101, 32'hFFFFFFFF, 6'd5, 32'h00001234, 3);

      // Store and load requested together: store first, load after
      st_valid = 1'b1; st_type = 2'b10; st_addr = 32'h70; st_value = 32'hCAFEF00D;
      ld_valid = 1'b1; ld_type = 3'b010; ld_addr = 32'h70; ld_dep = 6'd12;
      tick();
      st_valid = 1'b0;
      check("arb_accept0", {31'd0, ld_accept}, 32'd0);
      check("arb_store_wr", {31'd0, wr}, 32'd1);
      n = 0;
      for (int i = 1; i <= 10 && n == 0; i++) begin
         tick();
         if (ld_accept) n = i;
      end
      check("arb_accept_wait", n, 32'd5);
      ld_valid = 1'b0;
      n = 0;
      for (int i = 1; i <= 10 && n == 0; i++) begin
         tick();
         if (mvalid) n = i;
      end
      check("arb_load_lat", n, 32'd5);
      check("arb_load_value", mvalue, 32'hCAFEF00D);
      check("arb_load_dep", {26'd0, mdep}, 32'd12);

      // Flush 2 cycles into an LW
      ld_valid = 1'b1; ld_type = 3'b010; ld_addr = 32'h40; ld_dep = 6'd30;
      tick();
      ld_valid = 1'b0;
      check("fl_accept", {31'd0, ld_accept}, 32'd1);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1 check("fl_idle_busy", {31'd0, busy}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (mvalid) seen = 1'b1;
      end
      check("fl_no_valid", {31'd0, seen}, 32'd0);

      // Flush on the final load edge also drops the result
      ld_valid = 1'b1; ld_type = 3'b000; ld_addr = 32'h20; ld_dep = 6'd2;
      tick();
      ld_valid = 1'b0;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_last_valid", {31'd0, mvalid}, 32'd0);
      check("fl_last_busy", {31'd0, busy}, 32'd0);

      // Load request during flush is not accepted
      ld_valid = 1'b1; ld_type = 3'b000; ld_addr = 32'h20; ld_dep = 6'd6; flush = 1'b1;
      tick();
      check("fl_req_accept", {31'd0, ld_accept}, 32'd0);
      flush = 1'b0;
      do_load("post_flush_lb", 3'b000, 32'h20, 6'd6, 32'hFFFFFF80, 2);

      // Flush during SH: both bytes still written
      st_valid = 1'b1; st_type = 2'b01; st_addr = 32'h80; st_value = 32'h1234BEEF;
      tick();
      st_valid = 1'b0; flush = 1'b1;
      tick();
      check("sh_b1_wr", {31'd0, wr}, 32'd1);
      check("sh_b1_a", maddr, 32'h81);
      tick();
      flush = 1'b0;
      check("sh_end_busy", {31'd0, busy}, 32'd0);
      check("sh_ram", {16'd0, ram[12'h081], ram[12'h080]}, 32'h0000BEEF);

      // SB to IO with UART full for 3 edges
      st_valid = 1'b1; st_type = 2'b00; st_addr = 32'h30000; st_value = 32'h0000005A;
      io_full = 1'b1;
      tick();
      st_valid = 1'b0;
      check("io_stall0_wr", {31'd0, wr}, 32'd0);
      check("io_stall0_busy", {31'd0, busy}, 32'd1);
      tick();
      check("io_stall1_wr", {31'd0, wr}, 32'd0);
      check("io_stall1_busy", {31'd0, busy}, 32'd1);
      tick();
      check("io_stall2_wr", {31'd0, wr}, 32'd0);
      check("io_stall2_busy", {31'd0, busy}, 32'd1);
      io_full = 1'b0;
      tick();
      check("io_write_wr", {31'd0, wr}, 32'd1);
      check("io_write_a", maddr, 32'h30000);
      check("io_write_d", {24'd0, dout}, 32'h5A);
      check("io_write_busy", {31'd0, busy}, 32'd1);
      tick();
      check("io_end_busy", {31'd0, busy}, 32'd0);
      check("io_write_count", io_writes, 32'd1);
      check("io_write_byte", {24'd0, io_last}, 32'h5A);

      // rdy_in low freezes state and outputs
      ld_valid = 1'b1; ld_type = 3'b100; ld_addr = 32'h20; ld_dep = 6'd15;
      tick();
      ld_valid = 1'b0; rdy = 1'b0;
      tick(); tick(); tick();
      check("rdy_accept_held", {31'd0, ld_accept}, 32'd1);
      check("rdy_addr_held", maddr, 32'h20);
      rdy = 1'b1;
      n = 0;
      for (int i = 1; i <= 10 && n == 0; i++) begin
         tick();
         if (mvalid) n = i;
      end
      check("rdy_load_lat", n, 32'd2);
      check("rdy_load_value", mvalue, 32'h00000080);

      // Reset in the middle of an LW
      ld_valid = 1'b1; ld_type = 3'b010; ld_addr = 32'h40; ld_dep = 6'd1;
      tick();
      ld_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_busy", {31'd0, busy}, 32'd0);
      check("mrst_dep", {26'd0, mdep}, 32'h3F);
      check("mrst_value", mvalue, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (mvalid) seen = 1'b1;
      end
      check("mrst_no_valid", {31'd0, seen}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
